mem_uart_master: RTL and testbench
==================================

# mem_uart_master

CPU-side initiator for the serial memory protocol: accepts one memory request at a time from the core's memory stage and encodes it as a command/address/data byte stream for the UART transmitter. For reads it collects the returned bytes from the UART receiver and returns the assembled word. It sits between the core memory port and the byte-level UART and is the counterpart of the UART-attached RAM/IO responder.

## Interface
- TIMEOUT, 100000: cycles allowed for a read response, counted from entry into RDATA; 0 disables the timeout.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block idle; request accepted on req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_size  in  2  byte count minus 1 (0 = byte, 1 = half, 3 = word; 2 legal, 3 bytes).
- req_addr  in  32  byte address.
- req_wdata  in  32  write data, little-endian, low (req_size+1) bytes used.
- resp_valid  out  1  one-cycle completion pulse, reads and writes.
- resp_rdata  out  32  read data, zero-extended; 0 for writes.
- resp_err  out  1  valid with resp_valid; 1 = read timeout.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data valid; byte transferred on tx_valid && tx_ready.
- tx_ready  in  1  transmitter can take a byte.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  one-cycle pulse per received byte.

## Operation
- Request fields are captured on acceptance; the inputs may then change freely.
- Command byte: {1'b1, ~we, 4'b0000, size}. Write word = 0x83; read byte = 0xC0.
- Address encoding: A = little-endian bytes a0..a3. Send the 4 segment bytes {0, ai[6:0]} for i = 0..3, then the MSB byte {4'b0, a3[7], a2[7], a1[7], a0[7]}. Every byte after the command has bit 7 = 0.
- Write data: send seg bytes {0, di[6:0]} for i = 0..size, then the MSB byte {4'b0, msbs}. In msbs, bit i = di[7] for i <= size, and 0 for higher i.
- Read data: the responder returns size+1 raw bytes in order addr+0 .. addr+size. Byte i goes to resp_rdata[8i+7:8i]; higher bytes are 0.
- States:
  - IDLE: req_ready = 1; on accept go to CMD.
  - CMD → ADDR (ofs 0..3) → AMSB.
  - After AMSB: a write goes to WDATA (ofs 0..size) → WMSB → RESP; a read goes to RDATA → RESP.
  - RESP: resp_valid = 1 for one cycle, then IDLE.
- Each tx state holds tx_valid = 1 with stable tx_data until accepted, then advances the next cycle.
- RDATA: tx_valid = 0, and rx bytes are stored at ofs 0..size. After the last byte, go to RESP with resp_err = 0.
- Timeout: a counter runs in RDATA. If it reaches TIMEOUT (TIMEOUT != 0), go to RESP with resp_err = 1 and resp_rdata = bytes captured so far (others 0).
- rx_valid outside RDATA: the byte is dropped with no state change. That includes a late byte after a timeout.
- Byte counts: write = 1 + 5 + (size+1) + 1 bytes (word: 11); read = 6 tx bytes + (size+1) rx bytes.

## Timing
- Reset (async, immediate): state IDLE, req_ready 1, tx_valid 0, tx_data 0x00, resp_valid 0, resp_rdata 0, resp_err 0, counters 0.
- Reset mid-transfer aborts the transfer with no resp_valid, and tx_valid drops within the reset assertion. After release, the next request starts with a fresh command byte.
- req_ready falls the cycle after acceptance; the first tx_valid (command byte) is asserted that same cycle.
- A byte accepted in cycle n means the next byte's tx_valid/tx_data is presented in cycle n+1. With tx_ready tied high, the stream runs one byte per cycle.
- Write: resp_valid the cycle after the final MSB byte is accepted.
- Read: resp_valid the cycle after the rx_valid carrying the last byte; resp_rdata and resp_err are valid only during that pulse and held until the next response.
- req_ready rises the cycle after resp_valid. No back-to-back overlap: requests are strictly serialized.
- rx_valid in the same cycle as the final AMSB acceptance is dropped, because RDATA is entered the next cycle.

## Test plan
- Byte write: addr 0x00000104, data 0x41, size 0, tx_ready = 1.
  - Required tx stream: 80 04 01 00 00 00 41 00.
  - resp_valid 1 cycle after the last byte, resp_err 0.
- Word write: addr 0x80FF0080, data 0xDEADBEEF, size 3.
  - Required tx stream: 83 00 00 7F 00 0D 6F 3E 2D 5E 0F.
- Backpressure: same word write with tx_ready low for 5 cycles at random points.
  - tx_data and tx_valid stay stable while stalled; the stream is identical and the byte count is 11.
- Halfword read: addr 0x00001000, size 1.
  - Required tx stream: C1 00 10 00 00 00.
  - Drive rx 0x34, then 0x12 → resp_rdata 0x00001234, resp_err 0.
  - A stray rx byte sent while IDLE beforehand is ignored.
- Timeout: TIMEOUT = 1000, word read, rx supplies only AA, BB.
  - resp_valid exactly 1000 cycles after entering RDATA, with resp_err 1 and resp_rdata 0x0000BBAA.
  - The next request is accepted normally.
- Reset mid-write: assert rst after 3 bytes of a word write.
  - tx_valid is 0 immediately and there is no resp_valid.
  - After release req_ready = 1, and the next read begins with 0xC3.

Source files
------------

// File: rtl/mem_uart_master.sv
// mem_uart_master
//   CPU-side initiator for the serial memory protocol. Accepts one memory
//   request at a time, serialises it as command / address / write-data bytes
//   to a UART transmitter and, for reads, assembles the bytes returned by the
//   UART receiver into a little-endian word.
//
// Parameters
//   TIMEOUT    cycles allowed in RDATA before a read fails (0 = never)
// Ports
//   clk, rst   clock; asynchronous active-high reset
//   req_*      request handshake (valid/ready), we, size-1, byte addr, wdata
//   resp_*     one-cycle completion pulse with read data and timeout flag
//   tx_*       byte stream to UART transmitter (valid/ready)
//   rx_*       byte stream from UART receiver (one-cycle valid pulses)
module mem_uart_master #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, AMSB, WDATA, WMSB, RDATA, RESP
  } state_t;

  state_t      state, next;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic [1:0]  ofs;
  logic [31:0] cnt;

  logic        tx_fire;
  logic        rx_last;
  logic        timed_out;
  logic [31:0] rmerge;
  logic [3:0]  wmsbs;

  assign tx_fire   = tx_valid && tx_ready;
  assign rx_last   = rx_valid && (ofs == size);
  assign timed_out = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1));

  // Read buffer including the byte arriving this cycle, so the final byte
  // lands in resp_rdata on the same edge that enters RESP.
  always_comb begin
    rmerge = rbuf;
    if (rx_valid)
      rmerge[{ofs, 3'b000} +: 8] = rx_data;
  end

  always_comb begin
    wmsbs = '0;
    for (int unsigned i = 0; i < 4; i++)
      wmsbs[i] = wdata[8*i+7] && (i <= 32'(size));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next       = state;
    req_ready  = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next = CMD;
      end
      CMD: begin
        tx_valid = 1'b1;
        tx_data  = {1'b1, ~we, 4'b0000, size};
        if (tx_fire) next = ADDR;
      end
      ADDR: begin
        tx_valid = 1'b1;
        tx_data  = {1'b0, addr[{ofs, 3'b000} +: 7]};
        if (tx_fire && ofs == 2'd3) next = AMSB;
      end
      AMSB: begin
        tx_valid = 1'b1;
        tx_data  = {4'b0000, addr[31], addr[23], addr[15], addr[7]};
        if (tx_fire) next = we ? WDATA : RDATA;
      end
      WDATA: begin
        tx_valid = 1'b1;
        tx_data  = {1'b0, wdata[{ofs, 3'b000} +: 7]};
        if (tx_fire && ofs == size) next = WMSB;
      end
      WMSB: begin
        tx_valid = 1'b1;
        tx_data  = {4'b0000, wmsbs};
        if (tx_fire) next = RESP;
      end
      RDATA: begin
        if (rx_last || timed_out) next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        next       = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we         <= 1'b0;
      size       <= '0;
      addr       <= '0;
      wdata      <= '0;
      rbuf       <= '0;
      ofs        <= '0;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we    <= req_we;
            size  <= req_size;
            addr  <= req_addr;
            wdata <= req_wdata;
            rbuf  <= '0;
            ofs   <= '0;
          end
        end
        ADDR: begin
          if (tx_fire) ofs <= ofs + 2'd1;
        end
        AMSB: begin
          if (tx_fire) begin
            ofs <= '0;
            cnt <= '0;
          end
        end
        WDATA: begin
          if (tx_fire) ofs <= (ofs == size) ? 2'd0 : ofs + 2'd1;
        end
        WMSB: begin
          if (tx_fire) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        RDATA: begin
          cnt <= cnt + 32'd1;
          if (rx_valid) begin
            rbuf <= rmerge;
            ofs  <= ofs + 2'd1;
          end
          // A last byte arriving on the timeout cycle still completes cleanly.
          if (rx_last) begin
            resp_rdata <= rmerge;
            resp_err   <= 1'b0;
          end else if (timed_out) begin
            resp_rdata <= rmerge;
            resp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_uart_master.sv
module tb_mem_uart_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  mem_uart_master #(.TIMEOUT(1000)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  txq[$];
  logic [32:0] respq[$];   // {err, rdata}
  int tx_count = 0;
  int last_tx_cyc = 0;
  int resp_count = 0;
  int resp_cyc = 0;
  int last_rx_cyc = 0;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_data = '0;

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
          errors++;
          $display("FAIL stall_hold: tx_valid=%b tx_data=%h required 1/%h", tx_valid, tx_data, stall_data);
        end
        stall_pend = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        logic [7:0] e;
        checks++;
        if (txq.size() == 0) begin
          errors++;
          $display("FAIL tx_extra: got byte %h with nothing expected", tx_data);
        end else begin
          e = txq.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL tx_byte[%0d]: got %h required %h", tx_count, tx_data, e);
          end
        end
        tx_count++;
        last_tx_cyc = cyc;
      end else if (tx_valid && !tx_ready) begin
        stall_pend = 1'b1;
        stall_data = tx_data;
      end
      if (resp_valid) begin
        logic [32:0] r;
        checks++;
        if (respq.size() == 0) begin
          errors++;
          $display("FAIL resp_extra: got err=%b rdata=%h with nothing expected", resp_err, resp_rdata);
        end else begin
          r = respq.pop_front();
          if ({resp_err, resp_rdata} !== r) begin
            errors++;
            $display("FAIL resp: got err=%b rdata=%h required err=%b rdata=%h",
                     resp_err, resp_rdata, r[32], r[31:0]);
          end
        end
        resp_count++;
        resp_cyc = cyc;
      end
    end
  end

  task automatic push_model(input bit we, input logic [1:0] size,
                            input logic [31:0] a, input logic [31:0] d);
    logic [3:0] m;
    m = '0;
    txq.push_back({1'b1, ~we, 4'b0000, size});
    for (int i = 0; i < 4; i++) txq.push_back({1'b0, a[8*i +: 7]});
    txq.push_back({4'b0000, a[31], a[23], a[15], a[7]});
    if (we) begin
      for (int i = 0; i <= int'(size); i++) begin
        txq.push_back({1'b0, d[8*i +: 7]});
        m[i] = d[8*i+7];
      end
      txq.push_back({4'b0000, m});
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 after acceptance.
  task automatic issue(input bit we, input logic [1:0] size,
                       input logic [31:0] a, input logic [31:0] d);
    int t = 0;
    while (!req_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_wait: got %b required 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_size  = 2'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    checks++;
    if (req_ready !== 1'b0 || tx_valid !== 1'b1 || tx_data !== {1'b1, ~we, 4'b0000, size}) begin
      errors++;
      $display("FAIL accept: ready=%b tx_valid=%b tx_data=%h required 0/1/%h",
               req_ready, tx_valid, tx_data, {1'b1, ~we, 4'b0000, size});
    end
  endtask

  task automatic wait_tx(input int n, input int budget);
    int t = 0;
    while (tx_count < n && t < budget) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (tx_count < n) begin
      errors++;
      $display("FAIL tx_wait: got %0d bytes required %0d", tx_count, n);
    end
  endtask

  task automatic wait_resp(input int budget);
    int start = resp_count;
    int t = 0;
    while (resp_count == start && t < budget) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (resp_count == start) begin
      errors++;
      $display("FAIL resp_wait: no resp_valid within %0d cycles", budget);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = b; last_rx_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx: ready=%b tx_valid=%b tx_data=%h required 1/0/00", req_ready, tx_valid, tx_data);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: valid=%b rdata=%h err=%b required 0/0/0", resp_valid, resp_rdata, resp_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_byte_write();
    logic [7:0] exp[8] = '{8'h80, 8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h41, 8'h00};
    foreach (exp[i]) txq.push_back(exp[i]);
    respq.push_back({1'b0, 32'h0});
    tx_count = 0;
    issue(1'b1, 2'd0, 32'h0000_0104, 32'h0000_0041);
    wait_resp(100);
    checks++;
    if (tx_count != 8 || txq.size() != 0) begin
      errors++;
      $display("FAIL byte_write_count: got %0d bytes required 8", tx_count);
    end
    checks++;
    if (resp_cyc != last_tx_cyc + 1) begin
      errors++;
      $display("FAIL byte_write_latency: got %0d cycles required 1", resp_cyc - last_tx_cyc);
    end
  endtask

  task automatic test_word_write();
    logic [7:0] exp[11] = '{8'h83, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h0D,
                            8'h6F, 8'h3E, 8'h2D, 8'h5E, 8'h0F};
    foreach (exp[i]) txq.push_back(exp[i]);
    respq.push_back({1'b0, 32'h0});
    tx_count = 0;
    issue(1'b1, 2'd3, 32'h80FF_0080, 32'hDEAD_BEEF);
    wait_resp(100);
    checks++;
    if (tx_count != 11 || txq.size() != 0) begin
      errors++;
      $display("FAIL word_write_count: got %0d bytes required 11", tx_count);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[11] = '{8'h83, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h0D,
                            8'h6F, 8'h3E, 8'h2D, 8'h5E, 8'h0F};
    int stalls_left = 5;
    int t = 0;
    foreach (exp[i]) txq.push_back(exp[i]);
    respq.push_back({1'b0, 32'h0});
    tx_count = 0;
    issue(1'b1, 2'd3, 32'h80FF_0080, 32'hDEAD_BEEF);
    while (tx_count < 11 && t < 300) begin
      if (stalls_left > 0 && ($urandom_range(0, 3) == 0 || (11 - tx_count) <= 2)) begin
        tx_ready = 1'b0;
        stalls_left--;
      end else begin
        tx_ready = 1'b1;
      end
      @(posedge clk); #1; t++;
    end
    tx_ready = 1'b1;
    wait_resp(100);
    checks++;
    if (tx_count != 11 || txq.size() != 0 || stalls_left != 0) begin
      errors++;
      $display("FAIL backpressure_count: got %0d bytes, %0d stalls unused; required 11, 0", tx_count, stalls_left);
    end
  endtask

  task automatic test_half_read();
    logic [7:0] exp[6] = '{8'hC1, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
    int rc = resp_count;
    send_rx(8'h55);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (resp_count != rc || req_ready !== 1'b1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_rx: resp_count=%0d ready=%b tx_valid=%b required %0d/1/0", resp_count, req_ready, tx_valid, rc);
    end
    // 0x00001000: a1 = 0x10 -> segment 0x10, but bit-6..0 of 0x10 is 0x10.
    exp[2] = 8'h10;
    foreach (exp[i]) txq.push_back(exp[i]);
    respq.push_back({1'b0, 32'h0000_1234});
    tx_count = 0;
    issue(1'b0, 2'd1, 32'h0000_1000, 32'hFFFF_FFFF);
    wait_tx(6, 100);
    send_rx(8'h34);
    send_rx(8'h12);
    wait_resp(20);
    checks++;
    if (resp_cyc != last_rx_cyc + 1 || tx_count != 6) begin
      errors++;
      $display("FAIL half_read_latency: got %0d cycles, %0d bytes; required 1, 6", resp_cyc - last_rx_cyc, tx_count);
    end
  endtask

  task automatic test_timeout();
    int amsb_cyc;
    push_model(1'b0, 2'd3, 32'h0000_0200, 32'h0);
    respq.push_back({1'b1, 32'h0000_BBAA});
    tx_count = 0;
    issue(1'b0, 2'd3, 32'h0000_0200, 32'h0);
    wait_tx(6, 100);
    amsb_cyc = last_tx_cyc;
    send_rx(8'hAA);
    send_rx(8'hBB);
    wait_resp(1200);
    checks++;
    if (resp_cyc != amsb_cyc + 1001) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles after RDATA entry required 1000", resp_cyc - amsb_cyc - 1);
    end
    // Late byte after the timeout must be ignored; next request runs normally.
    send_rx(8'hCC);
    push_model(1'b1, 2'd2, 32'hC0A0_8001, 32'h00F0_81FE);
    respq.push_back({1'b0, 32'h0});
    tx_count = 0;
    issue(1'b1, 2'd2, 32'hC0A0_8001, 32'h00F0_81FE);
    wait_resp(100);
    checks++;
    if (tx_count != 10 || txq.size() != 0) begin
      errors++;
      $display("FAIL after_timeout_count: got %0d bytes required 10", tx_count);
    end
  endtask

  task automatic test_reset_mid_write();
    int rc;
    push_model(1'b1, 2'd3, 32'h1234_5678, 32'hCAFE_F00D);
    tx_count = 0;
    issue(1'b1, 2'd3, 32'h1234_5678, 32'hCAFE_F00D);
    wait_tx(3, 100);
    rc = resp_count;
    rst = 1'b1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: tx_valid=%b resp_valid=%b ready=%b required 0/0/1", tx_valid, resp_valid, req_ready);
    end
    txq.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (resp_count != rc || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_after: resp pulses=%0d ready=%b required 0/1", resp_count - rc, req_ready);
    end
    push_model(1'b0, 2'd3, 32'h8765_4321, 32'h0);
    respq.push_back({1'b0, 32'h1122_33F4});
    tx_count = 0;
    issue(1'b0, 2'd3, 32'h8765_4321, 32'h0);
    wait_tx(6, 100);
    send_rx(8'hF4);
    send_rx(8'h33);
    send_rx(8'h22);
    send_rx(8'h11);
    wait_resp(20);
    checks++;
    if (txq.size() != 0 || respq.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_leftover: tx=%0d resp=%0d expectations pending required 0/0", txq.size(), respq.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = '0;
    req_addr  = '0;
    req_wdata = '0;
    tx_ready  = 1'b1;
    rx_data   = '0;
    rx_valid  = 1'b0;
    #2;
    test_reset();
    test_byte_write();
    test_word_write();
    test_backpressure();
    test_half_read();
    test_timeout();
    test_reset_mid_write();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (respq.size() != 0 || txq.size() != 0) begin
      errors++;
      $display("FAIL final_queues: tx=%0d resp=%0d pending required 0/0", txq.size(), respq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
